// File: rtl/fsm_pkg.sv
// Shared state and BCD constants for the FSM timer blocks.
// Optional feature macro: FSM_TIMER_AUTO_RELOAD_EN.
package fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] bcd_clamp(
    input logic [3:0] d
  );
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD digit decrement with borrow out on 0 -> 9 wrap.
module bcd_digit_down
  import fsm_pkg::*;
(
  input  logic       i_dec,
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit,
  output logic       o_borrow
);

  always_comb begin
    o_digit  = i_digit;
    o_borrow = 1'b0;
    if (i_dec) begin
      if (i_digit == BCD_ZERO) begin
        o_digit  = BCD_MAX;
        o_borrow = 1'b1;
      end else begin
        o_digit = i_digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/fsm_bcd_timer.sv
// Loadable two-digit BCD countdown timer with pause and terminal flag.
// Define FSM_TIMER_AUTO_RELOAD_EN to reload from DONE on tick.
module fsm_bcd_timer
  import fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  output logic [3:0] cnt_ones,
  output logic [3:0] cnt_tens,
  output logic       bout,
  output logic       busy,
  output logic       done
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_ones;
  logic [3:0] r_tens;
  logic [3:0] w_ones_nxt;
  logic [3:0] w_tens_nxt;
  logic       r_bout;
  logic       r_busy;
  logic       r_done;
  logic       w_bout_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;

  logic       w_dec;
  logic [3:0] w_ones_dec;
  logic [3:0] w_tens_dec;
  logic       w_ones_brw;
  logic       w_tens_brw;
  logic [3:0] w_ld_ones;
  logic [3:0] w_ld_tens;

`ifdef FSM_TIMER_AUTO_RELOAD_EN
  logic [7:0] r_rl;
  logic [7:0] w_rl_nxt;
`endif

  assign w_ld_ones = bcd_clamp(load_val[3:0]);
  assign w_ld_tens = bcd_clamp(load_val[7:4]);
  assign w_dec     = (r_state == ST_RUN) & ~load & ~pause & tick;

  bcd_digit_down u_ones (
    .i_dec    (w_dec),
    .i_digit  (r_ones),
    .o_digit  (w_ones_dec),
    .o_borrow (w_ones_brw)
  );

  bcd_digit_down u_tens (
    .i_dec    (w_ones_brw),
    .i_digit  (r_tens),
    .o_digit  (w_tens_dec),
    .o_borrow (w_tens_brw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ones  <= BCD_ZERO;
      r_tens  <= BCD_ZERO;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ones  <= w_ones_nxt;
      r_tens  <= w_tens_nxt;
      r_bout  <= w_bout_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef FSM_TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rl <= 8'h00;
    else      r_rl <= w_rl_nxt;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ones_nxt  = r_ones;
    w_tens_nxt  = r_tens;
    w_bout_nxt  = 1'b0;
`ifdef FSM_TIMER_AUTO_RELOAD_EN
    w_rl_nxt    = r_rl;
`endif
    if (load) begin
      w_ones_nxt  = w_ld_ones;
      w_tens_nxt  = w_ld_tens;
      w_state_nxt = ST_IDLE;
`ifdef FSM_TIMER_AUTO_RELOAD_EN
      w_rl_nxt    = {w_ld_tens, w_ld_ones};
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!pause && start) begin
            if (r_ones == BCD_ZERO && r_tens == BCD_ZERO)
              w_state_nxt = ST_DONE;
            else
              w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            w_state_nxt = ST_PAUSE;
          end else if (tick) begin
            w_ones_nxt = w_ones_dec;
            w_tens_nxt = w_tens_dec;
            // a wrap below 00 can not happen in RUN; guard anyway
            w_bout_nxt = w_ones_brw & ~w_tens_brw;
            if (w_ones_dec == BCD_ZERO && w_tens_dec == BCD_ZERO)
              w_state_nxt = ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (!pause && start)
            w_state_nxt = ST_RUN;
        end
        ST_DONE: begin
`ifdef FSM_TIMER_AUTO_RELOAD_EN
          if (!pause && !start && tick && r_rl != 8'h00) begin
            w_ones_nxt  = r_rl[3:0];
            w_tens_nxt  = r_rl[7:4];
            w_state_nxt = ST_RUN;
          end
`endif
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  assign cnt_ones = r_ones;
  assign cnt_tens = r_tens;
  assign bout     = r_bout;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/fsm_bcd_timer.md
# fsm_bcd_timer

Loadable two-digit BCD down-counter built as an explicit FSM; the counting-down counterpart of the decade up-counter in the FSM block set. It takes a BCD preset (00–99), counts down one step per qualified `tick`, flags a borrow pulse whenever the ones digit wraps, and reports terminal count. It sits between a tick/prescaler source and control logic that needs a countdown with pause and terminal indication.

## Interface
- `clk`  input  1  system clock, rising edge
- `rst`  input  1  asynchronous, active-low reset
- `load`  input  1  load `load_val` into counter and reload register
- `load_val`  input  8  BCD preset: [7:4] tens, [3:0] ones
- `start`  input  1  begin/resume counting
- `pause`  input  1  suspend counting while in RUN
- `tick`  input  1  count qualifier; one decrement per cycle with `tick`=1 in RUN
- `cnt_ones`  output  4  ones digit, BCD
- `cnt_tens`  output  4  tens digit, BCD
- `bout`  output  1  one-cycle pulse when ones digit wraps 0→9
- `busy`  output  1  high in RUN or PAUSE
- `done`  output  1  high while in DONE
- No parameters.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Input priority, every state: `load` > `pause` > `start` > `tick`.
- `load`: digits ← `load_val`, reload register ← `load_val`, state → IDLE. Any nibble >9 is clamped to 9 (applies to both counter and reload register).
- IDLE: `start` with count ≠00 → RUN; `start` with count =00 → DONE. `pause`, `tick` ignored.
- RUN: `pause` → PAUSE, no decrement that cycle. Otherwise `tick` decrements by 1:
  - ones ≠0: ones−1.
  - ones =0: ones ← 9, tens−1, `bout` pulses.
  - Decrement resulting in 00 → DONE in the same edge.
  - `start` in RUN ignored.
- PAUSE: count frozen; `start` → RUN; `tick` ignored.
- DONE: count held at 00; exits only on `load` (→ IDLE) unless auto-reload is compiled in.
- `busy` = state ∈ {RUN, PAUSE}; `done` = state == DONE.

## Timing
- All outputs registered; input sampled at edge N is reflected at edge N (visible after N).
- Reset values: `cnt_ones`=0, `cnt_tens`=0, `bout`=0, `busy`=0, `done`=0, state IDLE, reload register 00.
- Reset asserted mid-count returns to reset values immediately, independent of `clk`.
- Load of 42, start, 42 ticks → `done` high after the 42nd tick edge.
- `bout` high exactly one cycle per wrap; never asserted on 01→00 (no tens borrow below 00).
- `load` and `tick` in same cycle: load wins, no decrement.

## Configuration
- `FSM_TIMER_AUTO_RELOAD_EN` defined: in DONE, a `tick` reloads digits from the reload register and returns to RUN (to DONE if reload value is 00, no change). `done` is therefore high from terminal edge until the next tick.
- Undefined: DONE is sticky until `load`; `tick` in DONE has no effect.

## Structure
- Shared package `fsm_pkg`: state encoding constants (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3), BCD constants (digit max 4'd9, zero 4'd0).
- Sub-module `bcd_digit_down`: one digit; inputs dec enable and current digit, outputs next digit and borrow. Instantiated twice, tens enable = ones borrow.

## Test plan
- Reset then load 8'h12, start, 12 ticks → counts 12,11,10,09…00; `bout` once at 10→09; `done`=1, `busy`=0 after tick 12.
- Load 8'h00, start → DONE next edge, `done`=1, no `bout`.
- Load 8'h35, start, 3 ticks, pause, 5 ticks, start, 1 tick → 32 held during pause, then 31; `busy` high throughout.
- Load 8'hAF (invalid) → counter reads 99; load during RUN at 57 with simultaneous tick → 99 in IDLE, no decrement.
- Async reset at count 47 mid-RUN → all outputs 0, state IDLE, before next clock edge.
- With `FSM_TIMER_AUTO_RELOAD_EN`: load 8'h03, start, 4 ticks → 02,01,00(`done`),03 back in RUN; without macro 4th tick leaves 00 and `done`=1.
